// File: rtl/cursor_cmd_pkg.sv
// Shared definitions for the cursor command controller.
//   - Key codes produced by the PS/2 keyboard decoder (level codes; 7..15 mean "no key").
//   - FSM state encoding for cursor_cmd_ctrl.
//   - Helpers: key code normalisation and single-axis cursor stepping.
package cursor_cmd_pkg;

  localparam logic [3:0] KEY_NONE   = 4'd0;
  localparam logic [3:0] KEY_UP     = 4'd1;
  localparam logic [3:0] KEY_DOWN   = 4'd2;
  localparam logic [3:0] KEY_LEFT   = 4'd3;
  localparam logic [3:0] KEY_RIGHT  = 4'd4;
  localparam logic [3:0] KEY_ENTER  = 4'd5;
  localparam logic [3:0] KEY_CANCEL = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_HOLD_DELAY  = 2'd1,
    ST_HOLD_REPEAT = 2'd2,
    ST_WAIT_ACK    = 2'd3
  } state_t;

  // Unused codes collapse to KEY_NONE so they behave exactly like a release.
  function automatic logic [3:0] norm_key(input logic [3:0] k);
    return (k > KEY_CANCEL) ? KEY_NONE : k;
  endfunction

  // One step along an axis whose legal range is 0..max.
  function automatic logic [3:0] step_coord(input logic [3:0] p, input logic inc,
                                            input logic [3:0] max, input logic wrap);
    if (inc) begin
      if (p == max) return wrap ? 4'd0 : max;
      return p + 4'd1;
    end
    if (p == 4'd0) return wrap ? max : 4'd0;
    return p - 4'd1;
  endfunction

endpackage

// File: rtl/cursor_cmd_ctrl_if.sv
// Move-command handshake between the cursor controller and the game engine.
//   cmd_valid  controller -> engine  move command pending
//   cmd_ready  engine -> controller  command accepted this cycle
//   cmd_src    controller -> engine  {x, y} source cell, stable while cmd_valid
//   cmd_dst    controller -> engine  {x, y} destination cell, stable while cmd_valid
//   busy       controller -> engine  controller is waiting for the acknowledge
interface cursor_cmd_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_src;
  logic [7:0] cmd_dst;
  logic       busy;

  modport master (output cmd_valid, output cmd_src, output cmd_dst, output busy,
                  input cmd_ready);
  modport slave  (input cmd_valid, input cmd_src, input cmd_dst, input busy,
                  output cmd_ready);
endinterface

// File: rtl/repeat_timer.sv
// Auto-repeat timer for a held direction key.
//   clk, rst_n  clock / async active-low reset
//   start       key newly pressed: step now, then wait DELAY cycles
//   hold        key still held: keep counting
//   step        one-cycle step pulse (combinational, consumed at the same edge)
// The counter is a down-counter; the terminal count is 0 and each terminal
// count reloads RATE-1 for the following repeat steps.
module repeat_timer #(
  parameter int unsigned DELAY = 25_000_000,
  parameter int unsigned RATE  = 10_000_000,
  parameter int unsigned CNT_W = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic hold,
  output logic step
);

  localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LOAD  = CNT_W'(RATE - 1);

  logic [CNT_W-1:0] cnt;
  logic             tc;

  assign tc   = hold && (cnt == '0);
  assign step = start || tc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= DELAY_LOAD;
    end else if (tc) begin
      cnt <= RATE_LOAD;
    end else if (hold) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/cursor_cmd_ctrl.sv
// Cursor command controller: turns level key codes into cursor moves with
// auto-repeat, runs the two-click select/commit sequence and issues move
// commands to the game engine.
//   clk, rst_n   clock / async active-low reset
//   key_state    level key code from the keyboard decoder
//   cur_x/cur_y  cursor position
//   sel_active   a source cell is selected; sel_pos = {sel_x, sel_y}
//   cmd          move-command handshake (master side)
//
// state          | meaning
// ST_IDLE        | no key held, waiting for a new press
// ST_HOLD_DELAY  | direction held, waiting for the first auto-repeat
// ST_HOLD_REPEAT | direction held, stepping every REPEAT_RATE cycles
// ST_WAIT_ACK    | command pending, keys ignored until cmd_ready
module cursor_cmd_ctrl
  import cursor_cmd_pkg::*;
#(
  parameter int unsigned GRID_W       = 8,
  parameter int unsigned GRID_H       = 8,
  parameter int unsigned REPEAT_DELAY = 25_000_000,
  parameter int unsigned REPEAT_RATE  = 10_000_000,
  parameter bit          WRAP         = 1'b0,
  parameter int unsigned CNT_W        = 25
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           key_state,
  output logic [3:0]           cur_x,
  output logic [3:0]           cur_y,
  output logic                 sel_active,
  output logic [7:0]           sel_pos,
  cursor_cmd_ctrl_if.master    cmd
);

  localparam logic [3:0] X_MAX = 4'(GRID_W - 1);
  localparam logic [3:0] Y_MAX = 4'(GRID_H - 1);

  state_t     state, state_n;
  logic [3:0] key, key_q;
  logic       new_press, is_dir, in_hold;
  logic       tmr_start, tmr_hold, tmr_step;
  logic       enter_act, cancel_act, enter_cmd, ack;
  logic       cmd_valid_q;
  logic [7:0] cmd_src_q, cmd_dst_q;

  assign key       = norm_key(key_state);
  assign new_press = (key != key_q) && (key != KEY_NONE);
  assign is_dir    = (key >= KEY_UP) && (key <= KEY_RIGHT);
  assign in_hold   = (state == ST_HOLD_DELAY) || (state == ST_HOLD_REPEAT);
  assign enter_cmd = sel_active && ({cur_x, cur_y} != sel_pos);
  assign ack       = (state == ST_WAIT_ACK) && cmd_valid_q && cmd.cmd_ready;

  // Timer controls are kept outside the FSM process so the FSM can read the
  // step pulse without a combinational loop through its own outputs.
  assign tmr_start = new_press && is_dir && (state != ST_WAIT_ACK);
  assign tmr_hold  = in_hold && (key != KEY_NONE) && (key == key_q);

  repeat_timer #(
    .DELAY (REPEAT_DELAY),
    .RATE  (REPEAT_RATE),
    .CNT_W (CNT_W)
  ) u_repeat_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .start (tmr_start),
    .hold  (tmr_hold),
    .step  (tmr_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n    = state;
    enter_act  = 1'b0;
    cancel_act = 1'b0;
    unique case (state)
      ST_IDLE, ST_HOLD_DELAY, ST_HOLD_REPEAT: begin
        if (new_press) begin
          if (is_dir) begin
            state_n = ST_HOLD_DELAY;
          end else if (key == KEY_ENTER) begin
            enter_act = 1'b1;
            state_n   = enter_cmd ? ST_WAIT_ACK : ST_IDLE;
          end else begin
            cancel_act = 1'b1;
            state_n    = ST_IDLE;
          end
        end else if (in_hold) begin
          if (key == KEY_NONE) state_n = ST_IDLE;
          else if (tmr_step && (state == ST_HOLD_DELAY)) state_n = ST_HOLD_REPEAT;
        end
      end
      ST_WAIT_ACK: begin
        if (ack) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q       <= KEY_NONE;
      cur_x       <= 4'd0;
      cur_y       <= 4'd0;
      sel_active  <= 1'b0;
      sel_pos     <= 8'd0;
      cmd_valid_q <= 1'b0;
      cmd_src_q   <= 8'd0;
      cmd_dst_q   <= 8'd0;
    end else begin
      // Tracks in every state, so a key held through WAIT_ACK is not a new press.
      key_q <= key;

      if (tmr_step) begin
        case (key)
          KEY_UP:    cur_y <= step_coord(cur_y, 1'b0, Y_MAX, WRAP);
          KEY_DOWN:  cur_y <= step_coord(cur_y, 1'b1, Y_MAX, WRAP);
          KEY_LEFT:  cur_x <= step_coord(cur_x, 1'b0, X_MAX, WRAP);
          KEY_RIGHT: cur_x <= step_coord(cur_x, 1'b1, X_MAX, WRAP);
          default: ;
        endcase
      end

      if (cancel_act) sel_active <= 1'b0;

      if (enter_act) begin
        if (!sel_active) begin
          sel_pos    <= {cur_x, cur_y};
          sel_active <= 1'b1;
        end else if (!enter_cmd) begin
          sel_active <= 1'b0;
        end else begin
          cmd_src_q   <= sel_pos;
          cmd_dst_q   <= {cur_x, cur_y};
          cmd_valid_q <= 1'b1;
        end
      end

      if (ack) begin
        cmd_valid_q <= 1'b0;
        sel_active  <= 1'b0;
      end
    end
  end

  assign cmd.cmd_valid = cmd_valid_q;
  assign cmd.cmd_src   = cmd_src_q;
  assign cmd.cmd_dst   = cmd_dst_q;
  assign cmd.busy      = (state == ST_WAIT_ACK);

endmodule
